// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - pipelined RISC-V immediate encoder with range check and delivery statistics
module imm_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_ImmSrc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    input  logic             clr_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count
);

    // Same encoding the immediate extender uses for its format select.
    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_U = 3'b011,
        SRC_J = 3'b100
    } imm_src_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1: raw request as accepted from the input port.
    logic        s1_valid;
    logic [2:0]  s1_src;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;

    // Flow control.
    logic s2_advance;
    logic s1_advance;
    logic out_hs;

    // Packing results computed from stage 1.
    logic [31:0] pack_instr;
    logic        pack_err;

    // Representability of the immediate in each format's field.
    logic fits_12;
    logic fits_13;
    logic fits_21;
    logic low12_zero;
    logic even;

    // Stage 2 is free when empty or draining this cycle; stage 1 moves whenever stage 2 does.
    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;
    assign out_hs     = out_valid && out_ready;

    // An N-bit signed field holds the value iff every bit from N-1 upward equals the sign.
    assign fits_12    = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign fits_13    = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
    assign fits_21    = (&s1_imm[31:20]) || !(|s1_imm[31:20]);
    assign low12_zero = !(|s1_imm[11:0]);
    assign even       = !s1_imm[0];

    // Scatter the immediate into format-specific positions; untouched bits come from base.
    always_comb begin
        pack_instr = s1_base;
        pack_err   = 1'b1;
        case (imm_src_e'(s1_src))
            SRC_I: begin
                pack_instr = {s1_imm[11:0], s1_base[19:0]};
                pack_err   = !fits_12;
            end
            SRC_S: begin
                pack_instr = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
                pack_err   = !fits_12;
            end
            SRC_B: begin
                pack_instr = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                              s1_imm[4:1], s1_imm[11], s1_base[6:0]};
                pack_err   = !(fits_13 && even);
            end
            SRC_U: begin
                pack_instr = {s1_imm[31:12], s1_base[11:0]};
                pack_err   = !low12_zero;
            end
            SRC_J: begin
                pack_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                              s1_imm[19:12], s1_base[11:0]};
                pack_err   = !(fits_21 && even);
            end
            default: begin
                // Unknown format: pass base through untouched and flag it.
                pack_instr = s1_base;
                pack_err   = 1'b1;
            end
        endcase
    end

    // Stage 1 register: load a new request whenever the stage is allowed to move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_src   <= 3'b000;
            s1_imm   <= 32'h0;
            s1_base  <= 32'h0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_src  <= in_ImmSrc;
                s1_imm  <= in_imm;
                s1_base <= in_base;
            end
        end
    end

    // Stage 2 register: hold the packed word stable while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_err   <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= pack_instr;
                out_err   <= pack_err;
            end
        end
    end

    // Delivery counters, saturating at all-ones so long runs never wrap back to small values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_count  <= '0;
            err_count <= '0;
        end else if (out_hs) begin
            if (out_err) begin
                if (!(&err_count)) begin
                    err_count <= err_count + CNT_ONE;
                end
            end else begin
                if (!(&ok_count)) begin
                    ok_count <= ok_count + CNT_ONE;
                end
            end
        end
    end

    // Sticky error flag; a delivered error in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (out_hs && out_err) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

endmodule
